// File: rtl/microcontrolador_gerador_pwm.sv
// -----------------------------------------------------------------------------
// microcontrolador_gerador_pwm
//
// Single-channel PWM generator fed by the 8-bit duty value from the output
// PIO. The period is (2^WIDTH-1) ticks, and the prescaler sets the tick rate.
// The stage drives complementary high/low-side outputs with dead-time
// insertion, and emits a one-clock pulse at every period wrap.
//
// Parameters
//   WIDTH       duty / period counter width (period = 2^WIDTH-1 ticks)
//   PRESCALE_W  prescaler divisor width
//   DEADTIME    dead band in clk cycles (0 = no dead band)
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   duty         requested duty (PIO out_port)
//   enable       1 = run, 0 = stop with outputs idle
//   prescale     a tick occurs every prescale+1 clocks
//   pwm_out      high-side PWM
//   pwm_out_n    low-side complementary PWM
//   period_tick  one-clock pulse on the edge where the counter wraps to 0
//   duty_active  duty value currently in force (shadow register)
// -----------------------------------------------------------------------------
module microcontrolador_gerador_pwm #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16,
  parameter int DEADTIME   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      duty,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  pwm_out,
  output logic                  pwm_out_n,
  output logic                  period_tick,
  output logic [WIDTH-1:0]      duty_active
);

  // The counter runs 0 .. 2^WIDTH-2, so the last count is all ones except the LSB.
  localparam logic [WIDTH-1:0]      CNT_LAST  = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0]      CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PRESC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  localparam int             DT_W    = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME);
  localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);

  logic [PRESCALE_W-1:0] r_presc_cnt;
  logic [WIDTH-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_duty_active;
  logic                  r_period_tick;
  logic                  r_raw_q;
  logic                  r_raw_d;
  logic                  r_raw_valid;
  logic                  r_prev_valid;
  logic [DT_W-1:0]       r_dt_cnt;
  logic                  r_pwm;
  logic                  r_pwm_n;

  logic w_tick;
  logic w_wrap;
  logic w_toggle;

  // ">=" rather than "==" so that lowering prescale below the current count
  // still produces a tick on the very next clock.
  assign w_tick = (r_presc_cnt >= prescale);
  assign w_wrap = w_tick && (r_cnt == CNT_LAST);

  // A dead band starts whenever raw_q changed on the previous edge. It also
  // starts when the previous sample was taken while idle, so that the first
  // edge after enable gets the same dead band as any other transition.
  assign w_toggle = !r_prev_valid || (r_raw_q != r_raw_d);

  // Prescaler, period counter and the wrap pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc_cnt   <= '0;
      r_cnt         <= '0;
      r_period_tick <= 1'b0;
    end else if (!enable) begin
      r_presc_cnt   <= '0;
      r_cnt         <= '0;
      r_period_tick <= 1'b0;
    end else begin
      if (w_tick) begin
        r_presc_cnt <= '0;
        r_cnt       <= w_wrap ? '0 : (r_cnt + CNT_ONE);
      end else begin
        r_presc_cnt <= r_presc_cnt + PRESC_ONE;
      end
      r_period_tick <= w_wrap;
    end
  end

  // Shadow duty: the shadow follows duty freely while idle. While running,
  // it updates only on the wrap clock, so a period is never cut short.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty_active <= '0;
    end else if (!enable || w_wrap) begin
      r_duty_active <= duty;
    end
  end

  // Compare stage plus the one-deep history used for edge detection.
  // The valid flags record whether each history sample was taken while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_raw_q      <= 1'b0;
      r_raw_d      <= 1'b0;
      r_raw_valid  <= 1'b0;
      r_prev_valid <= 1'b0;
    end else if (!enable) begin
      r_raw_q      <= 1'b0;
      r_raw_d      <= 1'b0;
      r_raw_valid  <= 1'b0;
      r_prev_valid <= 1'b0;
    end else begin
      r_raw_q      <= (r_cnt < r_duty_active);
      r_raw_d      <= r_raw_q;
      r_raw_valid  <= 1'b1;
      r_prev_valid <= r_raw_valid;
    end
  end

  // Dead-time stage. A toggle reloads the counter even when a dead band is
  // already running, so pulses of DEADTIME clocks or less never reach a pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dt_cnt <= '0;
      r_pwm    <= 1'b0;
      r_pwm_n  <= 1'b0;
    end else if (!enable) begin
      r_dt_cnt <= '0;
      r_pwm    <= 1'b0;
      r_pwm_n  <= 1'b0;
    end else if (w_toggle) begin
      if (DEADTIME == 0) begin
        r_dt_cnt <= '0;
        r_pwm    <= r_raw_valid & r_raw_q;
        r_pwm_n  <= r_raw_valid & ~r_raw_q;
      end else begin
        r_dt_cnt <= DT_LOAD;
        r_pwm    <= 1'b0;
        r_pwm_n  <= 1'b0;
      end
    end else if (r_dt_cnt > DT_ONE) begin
      r_dt_cnt <= r_dt_cnt - DT_ONE;
      r_pwm    <= 1'b0;
      r_pwm_n  <= 1'b0;
    end else begin
      // The last dead-band clock (count 1) ends here, so the matching side asserts.
      r_dt_cnt <= '0;
      r_pwm    <= r_raw_q;
      r_pwm_n  <= ~r_raw_q;
    end
  end

  assign pwm_out     = r_pwm;
  assign pwm_out_n   = r_pwm_n;
  assign period_tick = r_period_tick;
  assign duty_active = r_duty_active;

endmodule

// File: tb/tb_microcontrolador_gerador_pwm.sv
// -----------------------------------------------------------------------------
// Bench for microcontrolador_gerador_pwm. Two instances share the same inputs:
// instance A uses DEADTIME=2 and instance B uses DEADTIME=4. A reference model
// predicts every output on every cycle. In the model, an output is high only
// when the last DEADTIME+1 compare samples were all taken while running and
// all matched that output's polarity. Directed phases also check hand-computed
// period, high-time and dead-band counts.
// -----------------------------------------------------------------------------
module tb_microcontrolador_gerador_pwm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  duty;
  logic        enable;
  logic [15:0] prescale;

  logic       a_pwm, a_pwm_n, a_pt;
  logic [7:0] a_da;
  logic       b_pwm, b_pwm_n, b_pt;
  logic [7:0] b_da;

  always #5 clk = ~clk;

  microcontrolador_gerador_pwm #(.WIDTH(8), .PRESCALE_W(16), .DEADTIME(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .duty(duty), .enable(enable), .prescale(prescale),
    .pwm_out(a_pwm), .pwm_out_n(a_pwm_n), .period_tick(a_pt), .duty_active(a_da)
  );

  microcontrolador_gerador_pwm #(.WIDTH(8), .PRESCALE_W(16), .DEADTIME(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .duty(duty), .enable(enable), .prescale(prescale),
    .pwm_out(b_pwm), .pwm_out_n(b_pwm_n), .period_tick(b_pt), .duty_active(b_da)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_presc = 0;
  int         m_cnt   = 0;
  logic [7:0] m_da    = 8'd0;
  bit         m_pt    = 1'b0;
  bit         hv [0:7];       // history: sample was taken while running
  bit         hb [0:7];       // history: compare result (index 0 = newest)
  bit         m_a, m_an, m_b, m_bn;

  function automatic bit window_is(input int dt, input bit lvl);
    for (int k = 0; k <= dt; k++) begin
      if (!hv[k] || hb[k] != lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic push_hist(input bit v, input bit b);
    for (int k = 7; k > 0; k--) begin
      hv[k] = hv[k-1];
      hb[k] = hb[k-1];
    end
    hv[0] = v;
    hb[0] = b;
  endtask

  initial begin
    bit rawv, tick, wrap;
    for (int k = 0; k < 8; k++) begin hv[k] = 1'b0; hb[k] = 1'b0; end
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_presc = 0; m_cnt = 0; m_da = 8'd0; m_pt = 1'b0;
        m_a = 0; m_an = 0; m_b = 0; m_bn = 0;
        for (int k = 0; k < 8; k++) hv[k] = 1'b0;
      end else if (!enable) begin
        m_presc = 0; m_cnt = 0; m_da = duty; m_pt = 1'b0;
        m_a = 0; m_an = 0; m_b = 0; m_bn = 0;
        push_hist(1'b0, 1'b0);
      end else begin
        m_a  = window_is(2, 1'b1);
        m_an = window_is(2, 1'b0);
        m_b  = window_is(4, 1'b1);
        m_bn = window_is(4, 1'b0);
        rawv = (m_cnt < int'(m_da));
        tick = (m_presc >= int'(prescale));
        wrap = tick && (m_cnt == 254);
        if (tick) begin
          m_presc = 0;
          m_cnt   = wrap ? 0 : m_cnt + 1;
        end else begin
          m_presc = m_presc + 1;
        end
        if (wrap) m_da = duty;
        m_pt = wrap;
        push_hist(1'b1, rawv);
      end
      #1;
      check("cycle_a", {a_pwm, a_pwm_n, a_pt, a_da}, {m_a, m_an, m_pt, m_da});
      check("cycle_b", {b_pwm, b_pwm_n, b_pt, b_da}, {m_b, m_bn, m_pt, m_da});
      check("overlap_a", a_pwm & a_pwm_n, 0);
      check("overlap_b", b_pwm & b_pwm_n, 0);
    end
  end

  // ---------------- measurement helper ----------------
  int len, ha, hna, hb_cnt, hnb, la;
  logic [7:0] da_before, da_end;

  // Waits for a period_tick sample, then counts over the window up to the
  // next one. If chg_at > 0, duty is rewritten chg_at clocks into the window.
  task automatic measure(input int chg_at, input logic [7:0] nd);
    int guard;
    len = 0; ha = 0; hna = 0; hb_cnt = 0; hnb = 0; la = 0;
    da_before = 8'd0; da_end = 8'd0;
    guard = 0;
    while (!a_pt && guard < 5000) begin
      @(posedge clk); #2; guard++;
    end
    if (!a_pt) begin
      check("wait_tick_timeout", a_pt, 1);
      return;
    end
    do begin
      da_before = a_da;
      @(posedge clk); #2;
      len++;
      ha     += int'(a_pwm);
      hna    += int'(a_pwm_n);
      hb_cnt += int'(b_pwm);
      hnb    += int'(b_pwm_n);
      la     += int'(!a_pwm && !a_pwm_n);
      if (len == chg_at) duty = nd;
    end while (!a_pt && len < 5000);
    da_end = a_da;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int guard;
    logic [3:0] start_seq;
    reset_n = 1'b0; enable = 1'b0; duty = 8'd0; prescale = 16'd0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs_a", {a_pwm, a_pwm_n, a_pt, a_da}, 0);
    check("reset_outputs_b", {b_pwm, b_pwm_n, b_pt, b_da}, 0);
    reset_n = 1'b1;
    $display("phase reset: released");

    // Idle tracking of duty.
    duty = 8'd64;
    @(posedge clk); #2;
    check("idle_tracks_duty", a_da, 64);
    check("idle_outputs", {a_pwm, a_pwm_n, a_pt}, 0);
    $display("phase idle: duty_active=%0d", a_da);

    // Startup: the first raw edge is at E0, so pwm_out first asserts at E0+3.
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      start_seq[i] = a_pwm | a_pwm_n;
    end
    check("startup_dead_band", start_seq, 4'b1000);
    $display("phase startup: seq=%b", start_seq);

    // Steady state at duty 64.
    measure(0, 8'd0); measure(0, 8'd0); measure(0, 8'd0);
    check("steady_len", len, 255);
    check("steady_hi_a", ha, 62);
    check("steady_lo_a", hna, 189);
    check("steady_deadband_a", la, 4);
    check("steady_hi_b", hb_cnt, 60);
    check("steady_lo_b", hnb, 187);
    $display("phase steady: len=%0d hi=%0d lo=%0d dead=%0d", len, ha, hna, la);

    // Shadow update: the duty change at cnt=10 waits for the wrap.
    measure(10, 8'd128);
    check("shadow_cur_hi", ha, 62);
    check("shadow_da_before_wrap", da_before, 64);
    check("shadow_da_at_wrap", da_end, 128);
    measure(0, 8'd0);
    check("shadow_next_hi", ha, 126);
    check("shadow_next_lo", hna, 125);
    $display("phase shadow: next hi=%0d lo=%0d", ha, hna);

    // Extremes.
    duty = 8'd0;
    measure(0, 8'd0); measure(0, 8'd0); measure(0, 8'd0);
    check("duty0_hi", ha, 0);
    check("duty0_lo", hna, 255);
    duty = 8'd255;
    measure(0, 8'd0); measure(0, 8'd0); measure(0, 8'd0);
    check("duty255_hi", ha, 255);
    check("duty255_lo", hna, 0);
    check("duty255_dead", la, 0);
    $display("phase extremes: duty255 hi=%0d lo=%0d", ha, hna);

    // Prescaler.
    duty = 8'd100; prescale = 16'd3;
    measure(0, 8'd0); measure(0, 8'd0); measure(0, 8'd0);
    check("presc3_len", len, 1020);
    check("presc3_hi", ha, 398);
    check("presc3_lo", hna, 618);
    $display("phase prescale3: len=%0d hi=%0d", len, ha);

    prescale = 16'd9;
    guard = 0;
    while (m_presc != 5 && guard < 100) begin @(posedge clk); #2; guard++; end
    check("presc_reach5", m_presc, 5);
    prescale = 16'd2;
    @(posedge clk); #2;
    check("presc_shrink_tick", m_presc, 0);
    $display("phase prescale_shrink: guard=%0d", guard);

    // Short-pulse suppression on the DEADTIME=4 instance.
    prescale = 16'd0; duty = 8'd3;
    measure(0, 8'd0); measure(0, 8'd0); measure(0, 8'd0);
    check("short_hi_b", hb_cnt, 0);
    check("short_lo_b", hnb, 248);
    $display("phase short_pulse: b hi=%0d lo=%0d", hb_cnt, hnb);

    // Reset mid-period.
    repeat (50) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_a", {a_pwm, a_pwm_n, a_pt, a_da}, 0);
    check("async_reset_b", {b_pwm, b_pwm_n, b_pt, b_da}, 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    guard = 0;
    do begin @(posedge clk); #2; guard++; end while (!a_pt && guard < 1000);
    check("restart_first_wrap", guard, 255);
    $display("phase reset_mid: first wrap after %0d clocks", guard);

    // Disable.
    repeat (20) @(posedge clk);
    #2;
    enable = 1'b0;
    @(posedge clk); #2;
    check("disable_outputs", {a_pwm, a_pwm_n, a_pt}, 0);
    repeat (300) @(posedge clk);
    #2;
    check("disable_hold", {a_pwm, a_pwm_n, a_pt, b_pwm, b_pwm_n, b_pt}, 0);
    $display("phase disable: outputs idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
